// File: rtl/mask_bbox_tracker.sv
// Run-length filtered bounding box / pixel count tracker for the classifier mask stream.
// Publishes one result per frame over a valid/ready handshake; a blocked result is dropped.
module mask_bbox_tracker #(
    parameter int unsigned H_ACTIVE  = 618,
    parameter int unsigned V_ACTIVE  = 478,
    parameter int unsigned MIN_RUN   = 3,
    parameter int unsigned MIN_COUNT = 64
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        i_valid,
    input  logic [12:0] i_row,
    input  logic [12:0] i_col,
    input  logic        i_color,
    input  logic        i_box_ready,
    output logic        o_box_valid,
    output logic        o_found,
    output logic [12:0] o_xmin,
    output logic [12:0] o_xmax,
    output logic [12:0] o_ymin,
    output logic [12:0] o_ymax,
    output logic [19:0] o_count,
    output logic        o_drop
);

    localparam logic [12:0] H_ACT   = 13'(H_ACTIVE);
    localparam logic [12:0] V_ACT   = 13'(V_ACTIVE);
    localparam logic [12:0] H_LAST  = 13'(H_ACTIVE - 1);
    localparam logic [12:0] V_LAST  = 13'(V_ACTIVE - 1);
    localparam logic [3:0]  RUN_MAX = 4'(MIN_RUN);
    localparam logic [12:0] RUN_OFS = 13'(MIN_RUN - 1);
    localparam logic [19:0] CNT_MIN = 20'(MIN_COUNT);
    localparam logic [19:0] CNT_RUN = 20'(MIN_RUN);
    localparam logic [12:0] MIN_EMPTY = 13'h1FFF;

    typedef enum logic [0:0] {StSync, StAccum} state_e;

    state_e      state_q, state_d;
    logic [3:0]  run_q, run_d;
    logic [12:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [19:0] count_q, count_d;

    logic        box_valid_q, box_valid_d, found_q, found_d, drop_q, drop_d;
    logic [12:0] bxmin_q, bxmin_d, bxmax_q, bxmax_d, bymin_q, bymin_d, bymax_q, bymax_d;
    logic [19:0] bcount_q, bcount_d;

    logic        in_win, is_origin, is_end, process, hit, ramp, load;
    logic [3:0]  run_base, run_new;
    logic [12:0] base_xmin, base_xmax, base_ymin, base_ymax, cand_xmin;
    logic [12:0] upd_xmin, upd_xmax, upd_ymin, upd_ymax;
    logic [19:0] base_count, upd_count;

    assign in_win    = i_valid && (i_row < V_ACT) && (i_col < H_ACT);
    assign is_origin = (i_row == 13'd0) && (i_col == 13'd0);
    assign is_end    = (i_row == V_LAST) && (i_col == H_LAST);
    assign process   = in_win && ((state_q == StAccum) || is_origin);
    assign load      = process && is_end && (!box_valid_q || i_box_ready);

    // An origin pixel always starts from empty accumulators (new or aborted frame).
    assign base_xmin  = is_origin ? MIN_EMPTY : xmin_q;
    assign base_xmax  = is_origin ? 13'd0     : xmax_q;
    assign base_ymin  = is_origin ? MIN_EMPTY : ymin_q;
    assign base_ymax  = is_origin ? 13'd0     : ymax_q;
    assign base_count = is_origin ? 20'd0     : count_q;

    assign run_base = (i_col == 13'd0) ? 4'd0 : run_q;
    assign run_new  = !i_color ? 4'd0 : (run_base == RUN_MAX) ? RUN_MAX : run_base + 4'd1;
    assign hit      = i_color && (run_new == RUN_MAX);
    assign ramp     = (run_base != RUN_MAX);
    // On the qualifying transition the whole run so far is credited at once.
    assign cand_xmin = ramp ? i_col - RUN_OFS : i_col;

    assign upd_xmin  = (hit && cand_xmin < base_xmin) ? cand_xmin : base_xmin;
    assign upd_xmax  = (hit && i_col > base_xmax) ? i_col : base_xmax;
    assign upd_ymin  = (hit && i_row < base_ymin) ? i_row : base_ymin;
    assign upd_ymax  = (hit && i_row > base_ymax) ? i_row : base_ymax;
    assign upd_count = !hit ? base_count : base_count + (ramp ? CNT_RUN : 20'd1);

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        xmin_d      = xmin_q;
        xmax_d      = xmax_q;
        ymin_d      = ymin_q;
        ymax_d      = ymax_q;
        count_d     = count_q;
        box_valid_d = box_valid_q && !i_box_ready;
        found_d     = found_q;
        bxmin_d     = bxmin_q;
        bxmax_d     = bxmax_q;
        bymin_d     = bymin_q;
        bymax_d     = bymax_q;
        bcount_d    = bcount_q;
        drop_d      = 1'b0;

        if (process) begin
            state_d = StAccum;
            if (is_end) begin
                run_d   = 4'd0;
                xmin_d  = MIN_EMPTY;
                xmax_d  = 13'd0;
                ymin_d  = MIN_EMPTY;
                ymax_d  = 13'd0;
                count_d = 20'd0;
                if (load) begin
                    box_valid_d = 1'b1;
                    found_d     = (upd_count >= CNT_MIN);
                    bxmin_d     = found_d ? upd_xmin : 13'd0;
                    bxmax_d     = found_d ? upd_xmax : 13'd0;
                    bymin_d     = found_d ? upd_ymin : 13'd0;
                    bymax_d     = found_d ? upd_ymax : 13'd0;
                    bcount_d    = upd_count;
                end else begin
                    drop_d = 1'b1;
                end
            end else begin
                run_d   = run_new;
                xmin_d  = upd_xmin;
                xmax_d  = upd_xmax;
                ymin_d  = upd_ymin;
                ymax_d  = upd_ymax;
                count_d = upd_count;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q     <= StSync;
            run_q       <= 4'd0;
            xmin_q      <= MIN_EMPTY;
            xmax_q      <= 13'd0;
            ymin_q      <= MIN_EMPTY;
            ymax_q      <= 13'd0;
            count_q     <= 20'd0;
            box_valid_q <= 1'b0;
            found_q     <= 1'b0;
            bxmin_q     <= 13'd0;
            bxmax_q     <= 13'd0;
            bymin_q     <= 13'd0;
            bymax_q     <= 13'd0;
            bcount_q    <= 20'd0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            count_q     <= count_d;
            box_valid_q <= box_valid_d;
            found_q     <= found_d;
            bxmin_q     <= bxmin_d;
            bxmax_q     <= bxmax_d;
            bymin_q     <= bymin_d;
            bymax_q     <= bymax_d;
            bcount_q    <= bcount_d;
            drop_q      <= drop_d;
        end
    end

    assign o_box_valid = box_valid_q;
    assign o_found     = found_q;
    assign o_xmin      = bxmin_q;
    assign o_xmax      = bxmax_q;
    assign o_ymin      = bymin_q;
    assign o_ymax      = bymax_q;
    assign o_count     = bcount_q;
    assign o_drop      = drop_q;

endmodule

// File: tb/tb_mask_bbox_tracker.sv
// Directed bench for mask_bbox_tracker: three instances differing only in MIN_COUNT (1, 64, 128)
// share one sparse pixel stream; only pixels of interest plus the frame corners are driven.
module tb_mask_bbox_tracker;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        i_valid;
    logic [12:0] i_row, i_col;
    logic        i_color;
    logic        i_box_ready;

    logic        box_valid [3];
    logic        drop      [3];
    logic        found     [3];
    logic [12:0] xmin [3], xmax [3], ymin [3], ymax [3];
    logic [19:0] count [3];
    logic [72:0] res [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 iCLK = ~iCLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mask_bbox_tracker #(
            .MIN_COUNT((g == 0) ? 1 : ((g == 1) ? 64 : 128))
        ) u_dut (
            .iCLK        (iCLK),
            .iRST_N      (iRST_N),
            .i_valid     (i_valid),
            .i_row       (i_row),
            .i_col       (i_col),
            .i_color     (i_color),
            .i_box_ready (i_box_ready),
            .o_box_valid (box_valid[g]),
            .o_found     (found[g]),
            .o_xmin      (xmin[g]),
            .o_xmax      (xmax[g]),
            .o_ymin      (ymin[g]),
            .o_ymax      (ymax[g]),
            .o_count     (count[g]),
            .o_drop      (drop[g])
        );
        assign res[g] = {found[g], xmin[g], xmax[g], ymin[g], ymax[g], count[g]};
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic drive(input int r, input int c, input bit m);
        i_valid = 1'b1;
        i_row   = 13'(r);
        i_col   = 13'(c);
        i_color = m;
        tick();
        i_valid = 1'b0;
        i_color = 1'b0;
    endtask

    // Mask=1 on cols c0..c1 of row r, followed by a mask=0 pixel.
    task automatic mask_run(input int r, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) drive(r, c, 1'b1);
        drive(r, c1 + 1, 1'b0);
    endtask

    task automatic frame_end();
        drive(477, 617, 1'b0);
    endtask

    task automatic consume();
        i_box_ready = 1'b1;
        tick();
        i_box_ready = 1'b0;
    endtask

    task automatic test_reset();
        for (int g = 0; g < 3; g++) begin
            n_cmp++;
            if ({box_valid[g], drop[g], res[g]} !== 75'd0) begin
                n_err++;
                $display("FAIL reset[%0d] got %h want 0", g, {box_valid[g], drop[g], res[g]});
            end
        end
    endtask

    task automatic test_single_run();
        logic [72:0] exp_res [3];
        exp_res[0] = {1'b1, 13'd100, 13'd104, 13'd10, 13'd10, 20'd5};
        exp_res[1] = {1'b0, 13'd0, 13'd0, 13'd0, 13'd0, 20'd5};
        exp_res[2] = exp_res[1];
        drive(0, 0, 1'b0);
        drive(10, 99, 1'b0);
        mask_run(10, 100, 104);
        n_cmp++;
        if (box_valid[0] !== 1'b0) begin
            n_err++;
            $display("FAIL single_early_valid got %b want 0", box_valid[0]);
        end
        frame_end();
        n_cmp++;
        if ({box_valid[0], drop[0]} !== 2'b10) begin
            n_err++;
            $display("FAIL single_hs got %b want 10", {box_valid[0], drop[0]});
        end
        for (int g = 0; g < 3; g++) begin
            n_cmp++;
            if (res[g] !== exp_res[g]) begin
                n_err++;
                $display("FAIL single_res[%0d] got %h want %h", g, res[g], exp_res[g]);
            end
        end
        consume();
        n_cmp++;
        if (box_valid[0] !== 1'b0) begin
            n_err++;
            $display("FAIL single_consume got %b want 0", box_valid[0]);
        end
    endtask

    task automatic test_short_runs();
        drive(0, 0, 1'b0);
        drive(3, 5, 1'b1);
        drive(3, 6, 1'b0);
        drive(7, 20, 1'b1);
        drive(7, 21, 1'b1);
        drive(7, 700, 1'b1);   // out of window: must not extend the run
        drive(600, 22, 1'b1);  // out of window
        drive(7, 22, 1'b0);
        drive(100, 0, 1'b1);
        drive(100, 1, 1'b1);
        drive(100, 2, 1'b0);
        drive(200, 616, 1'b1);
        drive(200, 617, 1'b1);
        drive(201, 0, 1'b1);   // col 0 restarts the run
        drive(201, 1, 1'b0);
        frame_end();
        for (int g = 0; g < 3; g++) begin
            n_cmp++;
            if ({box_valid[g], res[g]} !== {1'b1, 73'd0}) begin
                n_err++;
                $display("FAIL short_res[%0d] got %h want %h", g, {box_valid[g], res[g]},
                         {1'b1, 73'd0});
            end
        end
        consume();
    endtask

    task automatic test_block();
        logic [72:0] exp_res [3];
        exp_res[0] = {1'b1, 13'd300, 13'd309, 13'd200, 13'd209, 20'd100};
        exp_res[1] = exp_res[0];
        exp_res[2] = {1'b0, 13'd0, 13'd0, 13'd0, 13'd0, 20'd100};
        drive(0, 0, 1'b0);
        for (int r = 200; r <= 209; r++) mask_run(r, 300, 309);
        frame_end();
        for (int g = 0; g < 3; g++) begin
            n_cmp++;
            if (res[g] !== exp_res[g]) begin
                n_err++;
                $display("FAIL block_res[%0d] got %h want %h", g, res[g], exp_res[g]);
            end
        end
    endtask

    // Block result still pending from test_block.
    task automatic test_back_to_back();
        logic [72:0] blk;
        logic [72:0] exp_c;
        blk   = {1'b1, 13'd300, 13'd309, 13'd200, 13'd209, 20'd100};
        exp_c = {1'b1, 13'd10, 13'd14, 13'd60, 13'd60, 20'd5};
        drive(0, 0, 1'b0);
        mask_run(50, 40, 43);
        frame_end();
        n_cmp++;
        if ({box_valid[0], drop[0], res[0]} !== {2'b11, blk}) begin
            n_err++;
            $display("FAIL b2b_drop got %h want %h", {box_valid[0], drop[0], res[0]},
                     {2'b11, blk});
        end
        tick();
        n_cmp++;
        if ({box_valid[0], drop[0], res[0]} !== {2'b10, blk}) begin
            n_err++;
            $display("FAIL b2b_hold got %h want %h", {box_valid[0], drop[0], res[0]},
                     {2'b10, blk});
        end
        consume();
        n_cmp++;
        if (box_valid[0] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_release got %b want 0", box_valid[0]);
        end
        // Load while idle, then a new load in the same cycle as the consume.
        drive(0, 0, 1'b0);
        mask_run(50, 40, 43);
        frame_end();
        drive(0, 0, 1'b0);
        mask_run(60, 10, 14);
        i_box_ready = 1'b1;
        frame_end();
        i_box_ready = 1'b0;
        n_cmp++;
        if ({box_valid[0], drop[0], res[0]} !== {2'b10, exp_c}) begin
            n_err++;
            $display("FAIL b2b_reload got %h want %h", {box_valid[0], drop[0], res[0]},
                     {2'b10, exp_c});
        end
        consume();
    endtask

    task automatic test_restart();
        logic [72:0] exp_res;
        exp_res = {1'b1, 13'd0, 13'd9, 13'd0, 13'd30, 20'd6};
        drive(0, 0, 1'b0);
        for (int r = 5; r <= 8; r++) mask_run(r, 20, 24);
        drive(0, 0, 1'b1);
        n_cmp++;
        if ({box_valid[0], drop[0]} !== 2'b00) begin
            n_err++;
            $display("FAIL restart_nodrop got %b want 00", {box_valid[0], drop[0]});
        end
        drive(0, 1, 1'b1);
        drive(0, 2, 1'b1);
        drive(0, 3, 1'b0);
        mask_run(30, 7, 9);
        frame_end();
        n_cmp++;
        if (res[0] !== exp_res) begin
            n_err++;
            $display("FAIL restart_res got %h want %h", res[0], exp_res);
        end
        n_cmp++;
        if ({found[1], count[1]} !== {1'b0, 20'd6}) begin
            n_err++;
            $display("FAIL restart_cnt64 got %h want %h", {found[1], count[1]}, {1'b0, 20'd6});
        end
        consume();
    endtask

    task automatic test_reset_mid();
        logic [72:0] exp_res;
        exp_res = {1'b1, 13'd2, 13'd4, 13'd4, 13'd4, 20'd3};
        drive(0, 0, 1'b0);
        mask_run(1, 1, 3);
        frame_end();
        n_cmp++;
        if ({box_valid[0], count[0]} !== {1'b1, 20'd3}) begin
            n_err++;
            $display("FAIL rst_pre got %h want %h", {box_valid[0], count[0]}, {1'b1, 20'd3});
        end
        iRST_N = 1'b0;
        tick();
        iRST_N = 1'b1;
        n_cmp++;
        if ({box_valid[0], drop[0], res[0]} !== 75'd0) begin
            n_err++;
            $display("FAIL rst_outputs got %h want 0", {box_valid[0], drop[0], res[0]});
        end
        mask_run(2, 5, 9);
        frame_end();
        n_cmp++;
        if ({box_valid[0], drop[0]} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_sync got %b want 00", {box_valid[0], drop[0]});
        end
        drive(0, 0, 1'b0);
        mask_run(4, 2, 4);
        frame_end();
        n_cmp++;
        if ({box_valid[0], res[0]} !== {1'b1, exp_res}) begin
            n_err++;
            $display("FAIL rst_after got %h want %h", {box_valid[0], res[0]}, {1'b1, exp_res});
        end
    endtask

    initial begin
        iRST_N      = 1'b0;
        i_valid     = 1'b0;
        i_row       = 13'd0;
        i_col       = 13'd0;
        i_color     = 1'b0;
        i_box_ready = 1'b0;
        tick();
        tick();
        test_reset();
        iRST_N = 1'b1;
        tick();
        test_single_run();
        test_short_runs();
        test_block();
        test_back_to_back();
        test_restart();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
